// File: rtl/bill_acceptor_pkg.sv
// bill_acceptor_pkg: shared FSM state encoding and default thresholds for the bill acceptor.
package bill_acceptor_pkg;
  typedef enum logic [2:0] {IDLE, MEASURE, RESULT, JAM, HOLD} state_t;
  localparam int TEN_MIN_DEF    = 2;
  localparam int TEN_MAX_DEF    = 4;
  localparam int TWENTY_MIN_DEF = 6;
  localparam int TWENTY_MAX_DEF = 8;
  localparam int JAM_LIMIT_DEF  = 15;
  localparam int GAP_DEF        = 2;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with synchronous active-low clear.
module sync2 (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (!clear) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/bill_acceptor.sv
// bill_acceptor: classifies bill-sensor pulse widths into Ten/Twenty/Reject pulses with jam detection.
module bill_acceptor
  import bill_acceptor_pkg::*;
#(
  parameter int TEN_MIN    = TEN_MIN_DEF,
  parameter int TEN_MAX    = TEN_MAX_DEF,
  parameter int TWENTY_MIN = TWENTY_MIN_DEF,
  parameter int TWENTY_MAX = TWENTY_MAX_DEF,
  parameter int JAM_LIMIT  = JAM_LIMIT_DEF,
  parameter int GAP        = GAP_DEF
) (
  input  logic Clock,
  input  logic Clear,
  input  logic BillSense,
  input  logic Ready,
  output logic Ten,
  output logic Twenty,
  output logic Reject,
  output logic Jam,
  output logic Busy
);
  localparam int WW = $clog2(JAM_LIMIT + 1);
  localparam int HW = $clog2(GAP + 1);
  localparam logic [WW-1:0] TMIN = WW'(TEN_MIN);
  localparam logic [WW-1:0] TMAX = WW'(TEN_MAX);
  localparam logic [WW-1:0] WMIN = WW'(TWENTY_MIN);
  localparam logic [WW-1:0] WMAX = WW'(TWENTY_MAX);
  localparam logic [WW-1:0] JLIM = WW'(JAM_LIMIT);
  localparam logic [WW-1:0] JPRE = WW'(JAM_LIMIT - 1);
  localparam logic [HW-1:0] HLAST = HW'(GAP - 1);

  if (TEN_MIN < 1 || TEN_MAX >= TWENTY_MIN || TWENTY_MAX >= JAM_LIMIT || GAP < 1) begin : g_bad_params
    $error("bill_acceptor: illegal parameter set");
  end

  state_t state, next;
  logic s;
  logic [WW-1:0] w, w_next;
  logic [HW-1:0] h, h_next;
  logic ten_n, twenty_n, reject_n;

  sync2 u_sync (.clk(Clock), .clear(Clear), .d(BillSense), .q(s));

  // Pulses are registered alongside the state, so the verdict is formed on the edge that opens RESULT.
  always_comb begin
    next = state;
    w_next = w;
    h_next = (state == HOLD) ? h + HW'(1) : '0;
    ten_n = 1'b0;
    twenty_n = 1'b0;
    reject_n = 1'b0;
    case (state)
      IDLE: if (s) begin
        next = MEASURE;
        w_next = WW'(1);
      end
      MEASURE: if (!s) begin
        next = RESULT;
        ten_n = Ready && w >= TMIN && w <= TMAX;
        twenty_n = Ready && w >= WMIN && w <= WMAX;
        reject_n = !ten_n && !twenty_n;
      end else if (w == JPRE) begin
        next = JAM;
        w_next = JLIM;
        reject_n = 1'b1;
      end else w_next = w + WW'(1);
      RESULT: next = HOLD;
      JAM: next = s ? JAM : HOLD;
      HOLD: next = (h == HLAST) ? IDLE : HOLD;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge Clock)
    if (!Clear) begin
      state <= IDLE;
      w <= '0;
      h <= '0;
      {Ten, Twenty, Reject, Jam, Busy} <= '0;
    end else begin
      state <= next;
      w <= w_next;
      h <= h_next;
      Ten <= ten_n;
      Twenty <= twenty_n;
      Reject <= reject_n;
      Jam <= next == JAM;
      Busy <= next != IDLE;
    end
endmodule

// File: tb/tb_bill_acceptor.sv
// tb_bill_acceptor: table-driven bench for bill widths, Ready gating, jams and mid-bill reset.
module tb_bill_acceptor;
  logic Clock = 1'b0, Clear = 1'b0, BillSense = 1'b0, Ready = 1'b0;
  logic Ten, Twenty, Reject, Jam, Busy;
  int checks = 0, errors = 0;
  int n_ten, n_tw, n_rej, n_both, pk, ik, jf, jl;

  typedef struct {
    int w, lo_a, lo_b, ten, tw, rej, pk, ik, jf, jl;
  } vec_t;
  vec_t vecs[16];

  bill_acceptor dut (
    .Clock(Clock), .Clear(Clear), .BillSense(BillSense), .Ready(Ready),
    .Ten(Ten), .Twenty(Twenty), .Reject(Reject), .Jam(Jam), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats;
    n_ten = 0; n_tw = 0; n_rej = 0; n_both = 0; pk = 0; ik = 0; jf = 0; jl = 0;
  endtask

  task automatic sample(input int k);
    n_ten += int'(Ten);
    n_tw += int'(Twenty);
    n_rej += int'(Reject);
    n_both += int'(Ten & Twenty);
    if ((Ten || Twenty || Reject) && pk == 0) pk = k;
    if (Busy) ik = k + 1;
    if (Jam) begin
      if (jf == 0) jf = k;
      jl = k;
    end
  endtask

  // Pin is high for edges 1..w; Ready is low for edges lo_a..lo_b.
  task automatic run(input int w, input int lo_a, input int lo_b);
    clear_stats();
    for (int k = 1; k <= w + 14; k++) begin
      BillSense = k <= w;
      Ready = !(k >= lo_a && k <= lo_b);
      tick();
      sample(k);
    end
    BillSense = 1'b0;
  endtask

  initial begin
    vecs = '{
      '{1, 0, 0, 0, 0, 1, 4, 7, 0, 0},
      '{2, 0, 0, 1, 0, 0, 5, 8, 0, 0},
      '{3, 0, 0, 1, 0, 0, 6, 9, 0, 0},
      '{4, 0, 0, 1, 0, 0, 7, 10, 0, 0},
      '{3, 0, 0, 1, 0, 0, 6, 9, 0, 0},
      '{5, 0, 0, 0, 0, 1, 8, 11, 0, 0},
      '{6, 0, 0, 0, 1, 0, 9, 12, 0, 0},
      '{7, 0, 0, 0, 1, 0, 10, 13, 0, 0},
      '{8, 0, 0, 0, 1, 0, 11, 14, 0, 0},
      '{9, 0, 0, 0, 0, 1, 12, 15, 0, 0},
      '{14, 0, 0, 0, 0, 1, 17, 20, 0, 0},
      '{3, 1, 99, 0, 0, 1, 6, 9, 0, 0},
      '{3, 4, 5, 1, 0, 0, 6, 9, 0, 0},
      '{7, 1, 99, 0, 0, 1, 10, 13, 0, 0},
      '{15, 0, 0, 0, 0, 1, 17, 20, 17, 17},
      '{20, 0, 0, 0, 0, 1, 17, 25, 17, 22}
    };
    repeat (3) tick();
    check("reset_outputs", int'({Ten, Twenty, Reject, Jam, Busy}), 0);
    Clear = 1'b1;
    repeat (2) tick();
    check("idle_outputs", int'({Ten, Twenty, Reject, Jam, Busy}), 0);

    for (int i = 0; i < 16; i++) begin
      run(vecs[i].w, vecs[i].lo_a, vecs[i].lo_b);
      check($sformatf("v%0d_w%0d ten", i, vecs[i].w), n_ten, vecs[i].ten);
      check($sformatf("v%0d_w%0d twenty", i, vecs[i].w), n_tw, vecs[i].tw);
      check($sformatf("v%0d_w%0d reject", i, vecs[i].w), n_rej, vecs[i].rej);
      check($sformatf("v%0d_w%0d ten_and_twenty", i, vecs[i].w), n_both, 0);
      check($sformatf("v%0d_w%0d pulse_cycle", i, vecs[i].w), pk, vecs[i].pk);
      check($sformatf("v%0d_w%0d idle_cycle", i, vecs[i].w), ik, vecs[i].ik);
      check($sformatf("v%0d_w%0d jam_first", i, vecs[i].w), jf, vecs[i].jf);
      check($sformatf("v%0d_w%0d jam_last", i, vecs[i].w), jl, vecs[i].jl);
    end

    // 7-cycle bill with Clear low on edge 5: first bill aborts, the remaining 2 high cycles form a Ten.
    clear_stats();
    Ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      BillSense = k <= 7;
      Clear = k != 5;
      tick();
      if (k == 4) check("midbill_busy", int'(Busy), 1);
      if (k == 5) check("midbill_reset_outputs", int'({Ten, Twenty, Reject, Jam, Busy}), 0);
      sample(k);
    end
    Clear = 1'b1;
    BillSense = 1'b0;
    check("midbill ten", n_ten, 1);
    check("midbill twenty", n_tw, 0);
    check("midbill reject", n_rej, 0);
    check("midbill pulse_cycle", pk, 10);
    check("midbill idle_cycle", ik, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bill_acceptor.md
BILL_ACCEPTOR -- requirements
Module: bill_acceptor

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- TEN_MIN, 2: minimum high width, in cycles, classified as a 10.
- TEN_MAX, 4: maximum high width classified as a 10.
- TWENTY_MIN, 6: minimum high width classified as a 20.
- TWENTY_MAX, 8: maximum high width classified as a 20.
- JAM_LIMIT, 15: high width at which a jam is declared.
- GAP, 2: hold-off cycles after any result before a new bill is measured.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clock, input, 1: the only clock; all logic on the rising edge.
- Clear, input, 1: synchronous, active-low reset.
- BillSense, input, 1: raw, asynchronous bill-reader sensor; high while a bill passes.
- Ready, input, 1: high when the downstream ticket machine is accepting money.
- Ten, output, 1: one-cycle pulse for a valid 10 bill; feeds the ticket machine Ten input.
- Twenty, output, 1: one-cycle pulse for a valid 20 bill; feeds the ticket machine Twenty input.
- Reject, output, 1: one-cycle pulse when a bill is refused or jams.
- Jam, output, 1: level; high while in the jam condition.
- Busy, output, 1: level; high whenever state is not IDLE.

Function
REQ-003 BillSense SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized level S.

REQ-004 The FSM SHALL have states IDLE, MEASURE, RESULT, JAM and HOLD.

REQ-005 In IDLE with S=1, the FSM SHALL go to MEASURE with the width counter W loaded to 1.

REQ-006 In MEASURE with S=1, W SHALL increment, saturating at JAM_LIMIT (4-bit counter for the defaults).

REQ-007 In MEASURE, when S=1 and W reaches JAM_LIMIT, the FSM SHALL go to JAM.

REQ-008 In MEASURE with S=0, the FSM SHALL go to RESULT and hold the final W, which equals the number of cycles S was high.

REQ-009 In RESULT, exactly one of Ten, Twenty or Reject SHALL be high for that single cycle:
- Ten when Ready=1 and TEN_MIN<=W<=TEN_MAX.
- Twenty when Ready=1 and TWENTY_MIN<=W<=TWENTY_MAX.
- Reject otherwise, including any Ready=0 case.

REQ-010 Ready SHALL be sampled in the RESULT cycle only; changes of Ready during MEASURE have no effect.

REQ-011 Latency: the result pulse SHALL appear 1 cycle after the cycle in which MEASURE first samples S=0, which is 3 cycles after BillSense falls at the pin.

REQ-012 On entering JAM, Reject SHALL pulse for 1 cycle and Jam SHALL go high. Jam SHALL stay high until S is sampled 0, then the FSM SHALL go to HOLD.

REQ-013 RESULT SHALL always go to HOLD. HOLD SHALL last GAP cycles, ignoring S, then return to IDLE.

REQ-014 If S is still 1 on return to IDLE, this SHALL count as a new bill (REQ-005).

REQ-015 Ten and Twenty SHALL never be high together, and no output pulse SHALL exceed 1 cycle.

REQ-016 Widths of 0 cycles are impossible because MEASURE is entered with W=1. Widths between ranges (5 and 9..14 with defaults) SHALL produce Reject.

REQ-017 Parameter legality SHALL be checked at elaboration: TEN_MIN>=1, TEN_MAX<TWENTY_MIN, TWENTY_MAX<JAM_LIMIT.

Reset
REQ-018 While Clear=0 at a rising edge, the block SHALL go to IDLE with W=0, the synchronizer flops=0, and Ten, Twenty, Reject, Jam and Busy=0.

REQ-019 A reset asserted mid-MEASURE, RESULT or JAM SHALL abort without emitting any pulse.

REQ-020 After Clear returns high, a BillSense that is already high SHALL be treated as a new bill once the synchronizer shows 1.

Structure
REQ-021 The state enum and default parameter values SHALL live in shared package bill_acceptor_pkg.

REQ-022 The synchronizer SHALL be a separate sub-module, sync2, reusable by the ticket machine.

REQ-023 Outputs SHALL be registered (Moore style), so there is no combinational path from Ready or BillSense to any output.

Verification
REQ-024 After reset, a BillSense high for 3 cycles with Ready=1 -> one Ten pulse, no Twenty or Reject; Busy returns low GAP+1 cycles after the pulse.

REQ-025 A BillSense high for 7 cycles with Ready=1 -> one Twenty pulse. Running four 10 bills back-to-back into a connected ticket machine -> Dispense asserted after the fourth.

REQ-026 Widths 1, 5 and 9 with Ready=1 -> Reject each time, Ten and Twenty never high.

REQ-027 A BillSense high for 3 cycles with Ready=0 in the RESULT cycle -> Reject. A width-3 bill where Ready drops only during MEASURE and is 1 at RESULT -> Ten.

REQ-028 A BillSense held high for 20 cycles -> Reject pulse in the JAM-entry cycle, Jam high until 2 cycles after the sense falls, then HOLD, then IDLE, with no Ten or Twenty.

REQ-029 Clear=0 for 1 cycle during width-5 MEASURE of a 7-cycle bill -> no output pulse from that bill. The remaining high cycles SHALL be measured as a new bill.
